// File: rtl/tick_sched_pkg.sv
// Shared types and default constants for the tick scheduler.
// Channel states and the Basys 3 clock defaults live here so the top and channels agree.
package tick_sched_pkg;

    localparam int unsigned DefaultSysHz = 100_000_000;
    localparam int unsigned DefaultCntW  = 27;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        RUN
    } ch_state_t;

endpackage

// File: rtl/tick_channel.sv
// One tick channel: IDLE/ARMED/RUN state, latched divisor and a down counter.
// The first tick lands on the epoch-zero cycle; later ticks follow every div cycles.
module tick_channel
    import tick_sched_pkg::*;
#(
    parameter int unsigned CNT_W = DefaultCntW
) (
    input  logic             sysclk,
    input  logic             rst,
    input  logic             epoch_zero_next,
    input  logic             load,
    input  logic             load_en,
    input  logic [CNT_W-1:0] load_div,
    output logic             tick,
    output logic             active
);

    ch_state_t        state_q, state_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge sysclk) begin
        if (rst) begin
            state_q <= IDLE;
            div_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            ARMED: begin
                if (epoch_zero_next) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                // cnt_q counts cycles remaining until the next tick.
                if (cnt_q == '0) begin
                    cnt_d = div_q - CNT_W'(1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A load overrides whatever the channel was doing.
        if (load) begin
            if (load_en) begin
                div_d = load_div;
                if (epoch_zero_next) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    state_d = ARMED;
                end
            end else begin
                state_d = IDLE;
            end
        end
    end

    assign tick   = (state_q == RUN) && (cnt_q == '0);
    assign active = (state_q == RUN);

endmodule

// File: rtl/tick_scheduler.sv
// Multi-channel clock-enable scheduler: shared epoch counter, config handshake and error check.
// Every output is decoded from registers and forced low while rst is high.
module tick_scheduler
    import tick_sched_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned SYS_HZ = DefaultSysHz,
    parameter int unsigned CNT_W  = DefaultCntW,
    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              sysclk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic              cfg_en,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] ch_active,
    output logic              sec_tick
);

    localparam int unsigned EP_W = (SYS_HZ > 1) ? $clog2(SYS_HZ) : 1;
    localparam logic [EP_W-1:0] EpLast = EP_W'(SYS_HZ - 1);

    logic [EP_W-1:0]   epoch_q, epoch_d;
    logic              epoch_last;
    logic              commit_q;
    logic              err_q;
    logic              accept;
    logic              req_bad;
    logic [NUM_CH-1:0] load;
    logic [NUM_CH-1:0] tick_raw;
    logic [NUM_CH-1:0] active_raw;

    assign epoch_last = (epoch_q == EpLast);
    assign epoch_d    = epoch_last ? '0 : epoch_q + EP_W'(1);

    // Ready is low for the commit cycle that follows each accept.
    assign cfg_ready = ~rst & ~commit_q;
    assign accept    = cfg_valid & cfg_ready;
    assign req_bad   = (32'(cfg_ch) >= NUM_CH) | (cfg_en & (cfg_div == '0));

    always_ff @(posedge sysclk) begin
        if (rst) begin
            epoch_q  <= '0;
            commit_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            epoch_q  <= epoch_d;
            commit_q <= accept;
            err_q    <= accept & req_bad;
        end
    end

    always_comb begin
        load = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            load[i] = accept & ~req_bad & (32'(cfg_ch) == i);
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        tick_channel #(
            .CNT_W(CNT_W)
        ) u_ch (
            .sysclk          (sysclk),
            .rst             (rst),
            .epoch_zero_next (epoch_last),
            .load            (load[g]),
            .load_en         (cfg_en),
            .load_div        (cfg_div),
            .tick            (tick_raw[g]),
            .active          (active_raw[g])
        );
    end

    assign tick      = tick_raw & {NUM_CH{~rst}};
    assign ch_active = active_raw & {NUM_CH{~rst}};
    assign sec_tick  = epoch_last & ~rst;
    assign cfg_err   = err_q & ~rst;

endmodule

// File: tb/tb_tick_scheduler.sv
// Scoreboard bench for tick_scheduler: a cycle model pushes expected outputs per driven cycle,
// a negedge monitor pops and compares them against the DUT.
module tb_tick_scheduler;
    import tick_sched_pkg::*;

    localparam int NUM_CH = 3;
    localparam int SYS_HZ = 20;
    localparam int CNT_W  = 8;
    localparam int CH_W   = 2;

    logic              sysclk = 1'b0;
    logic              rst;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [CH_W-1:0]   cfg_ch;
    logic [CNT_W-1:0]  cfg_div;
    logic              cfg_en;
    logic              cfg_err;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] ch_active;
    logic              sec_tick;

    always #5 sysclk = ~sysclk;

    tick_scheduler #(
        .NUM_CH(NUM_CH),
        .SYS_HZ(SYS_HZ),
        .CNT_W (CNT_W)
    ) dut (
        .sysclk    (sysclk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_en    (cfg_en),
        .cfg_err   (cfg_err),
        .tick      (tick),
        .ch_active (ch_active),
        .sec_tick  (sec_tick)
    );

    typedef struct {
        logic [NUM_CH-1:0] tick;
        logic [NUM_CH-1:0] act;
        logic              sec;
        logic              err;
        logic              rdy;
    } exp_t;

    exp_t sb_q[$];

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state (spec-level: alignment cycle plus modular phase).
    int        m_e      = 0;
    int        m_cyc    = 0;
    bit        m_commit = 1'b0;
    bit        m_err    = 1'b0;
    ch_state_t m_st[NUM_CH];
    int        m_div[NUM_CH];
    int        m_align[NUM_CH];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s t=%0t: got %0h want %0h", tag, $time, got, want);
        end
    endtask

    always @(negedge sysclk) begin
        if (sb_q.size() != 0) begin
            exp_t x;
            x = sb_q.pop_front();
            check_val("tick",      32'(tick),      32'(x.tick));
            check_val("ch_active", 32'(ch_active), 32'(x.act));
            check_val("sec_tick",  32'(sec_tick),  32'(x.sec));
            check_val("cfg_err",   32'(cfg_err),   32'(x.err));
            check_val("cfg_ready", 32'(cfg_ready), 32'(x.rdy));
        end
    end

    // One clock cycle: apply inputs, predict this cycle's outputs, then advance the model.
    task automatic drive(input bit r, input bit v, input int ch, input int dv, input bit en);
        exp_t x;
        bit   acc;
        bit   bad;
        rst       = r;
        cfg_valid = v;
        cfg_ch    = CH_W'(ch);
        cfg_div   = CNT_W'(dv);
        cfg_en    = en;

        x.tick = '0;
        x.act  = '0;
        x.sec  = 1'b0;
        x.err  = 1'b0;
        x.rdy  = 1'b0;
        if (!r) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (m_st[c] == ARMED && m_e == 0) begin
                    m_st[c]    = RUN;
                    m_align[c] = m_cyc;
                end
            end
            x.sec = (m_e == SYS_HZ - 1);
            x.rdy = !m_commit;
            x.err = m_err;
            for (int c = 0; c < NUM_CH; c++) begin
                x.act[c]  = (m_st[c] == RUN);
                x.tick[c] = (m_st[c] == RUN) && (((m_cyc - m_align[c]) % m_div[c]) == 0);
            end
        end
        sb_q.push_back(x);

        @(negedge sysclk);
        if (r) begin
            m_e      = 0;
            m_commit = 1'b0;
            m_err    = 1'b0;
            for (int c = 0; c < NUM_CH; c++) m_st[c] = IDLE;
        end else begin
            acc = v && !m_commit;
            bad = (ch >= NUM_CH) || (en && dv == 0);
            if (acc && !bad) begin
                if (en) begin
                    m_div[ch] = dv;
                    m_st[ch]  = ARMED;
                end else begin
                    m_st[ch] = IDLE;
                end
            end
            m_commit = acc;
            m_err    = acc && bad;
            m_e      = (m_e + 1) % SYS_HZ;
        end
        m_cyc++;
        @(posedge sysclk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic send(input int ch, input int dv, input bit en);
        drive(1'b0, 1'b1, ch, dv, en);
    endtask

    task automatic wait_e(input int target);
        for (int k = 0; k < SYS_HZ && m_e != target; k++) idle(1);
    endtask

    initial begin
        for (int c = 0; c < NUM_CH; c++) begin
            m_st[c]    = IDLE;
            m_div[c]   = 1;
            m_align[c] = 0;
        end

        // Reset held for 3 cycles, then a full epoch to see the first sec_tick.
        repeat (3) drive(1'b1, 1'b0, 0, 0, 1'b0);
        wait_e(5);
        send(0, 4, 1'b1);
        idle(45);

        // Coincident start: div=1 and a non-dividing div=7 armed in the same epoch.
        wait_e(3);
        send(1, 1, 1'b1);
        idle(1);
        send(2, 7, 1'b1);
        idle(50);

        // Rejected requests: zero divisor with en=1, out-of-range channel.
        send(0, 0, 1'b1);
        idle(2);
        send(3, 5, 1'b1);
        idle(2);

        // Re-arm ch0 on a cycle where it is due to tick, then stop it mid-run.
        wait_e(8);
        send(0, 3, 1'b1);
        idle(30);
        send(0, 5, 1'b0);
        idle(5);
        send(2, 0, 1'b0);
        idle(3);

        // Back-to-back: valid held high, accepts land every other cycle.
        for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, i % 3, i + 2, 1'b1);
        idle(25);

        // Mid-run reset with all three channels running.
        repeat (2) drive(1'b1, 1'b0, 0, 0, 1'b0);
        idle(25);

        for (int i = 0; i < 20; i++) begin
            send(int'($urandom_range(0, 3)), int'($urandom_range(0, 9)),
                 1'($urandom_range(0, 1)));
            idle(int'($urandom_range(1, 10)));
        end
        idle(25);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
